// File: rtl/sram_rw_port_arbiter_pkg.sv
// Shared definitions for the SRAM RW-port arbiter: macro geometry,
// requester ids and the request payload carried from each requester.
package sram_rw_port_arbiter_pkg;

  // Geometry of the 32x256 OpenRAM macro
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned NUM_WMASKS = DATA_WIDTH / 8;

  // Requester ids as carried down the response pipe
  localparam logic REQ_LSU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } sram_req_t;

  // Byte enables presented to the macro: reads never carry a mask
  function automatic logic [NUM_WMASKS-1:0] macro_wmask(input sram_req_t req);
    return req.we ? req.wmask : '0;
  endfunction

endpackage

// File: rtl/sram_rsp_pipe.sv
// Two-stage response pipe for the SRAM RW port.
// Stage A records an issued request (valid/id/we) at the end of the issue
// cycle; stage B turns it into a one-cycle response and captures the macro
// read data, giving a fixed latency of two cycles.
// Ports:
//   clk, rstb          clock, async active-low reset
//   i_issue_valid/id/we  request granted this cycle
//   i_dout             macro read data (stable after the falling edge)
//   o_rsp0_valid/o_rsp1_valid  response strobe per requester
//   o_rsp_rdata        read data (0 for write acks), held between responses
module sram_rsp_pipe
  import sram_rw_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  i_issue_valid,
  input  logic                  i_issue_id,
  input  logic                  i_issue_we,
  input  logic [DATA_WIDTH-1:0] i_dout,
  output logic                  o_rsp0_valid,
  output logic                  o_rsp1_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_rdata
);

  logic                  r_a_valid;
  logic                  r_a_id;
  logic                  r_a_we;
  logic                  r_rsp0_valid;
  logic                  r_rsp1_valid;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  // Stage A: request in flight inside the macro
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_a_valid <= 1'b0;
      r_a_id    <= REQ_LSU;
      r_a_we    <= 1'b0;
    end else begin
      r_a_valid <= i_issue_valid;
      r_a_id    <= i_issue_id;
      r_a_we    <= i_issue_we;
    end
  end

  // Stage B: response registers; data only moves when a response is produced
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp_rdata  <= '0;
    end else begin
      r_rsp0_valid <= r_a_valid && (r_a_id == REQ_LSU);
      r_rsp1_valid <= r_a_valid && (r_a_id == REQ_LDR);
      if (r_a_valid) begin
        r_rsp_rdata <= r_a_we ? '0 : i_dout;
      end
    end
  end

  assign o_rsp0_valid = r_rsp0_valid;
  assign o_rsp1_valid = r_rsp1_valid;
  assign o_rsp_rdata  = r_rsp_rdata;

endmodule

// File: rtl/sram_rw_port_arbiter.sv
// Round-robin arbiter sharing the RW port (port 0) of the OpenRAM macro
// between the core LSU (req0) and the loader/debug path (req1).
// Ports:
//   clk, rstb                 clock, async active-low reset
//   reqN_valid/ready          request handshake (ready = grant, combinational)
//   reqN_we/wmask/addr/wdata  request fields, held stable until accepted
//   rsp0_valid/rsp1_valid     in-order responses, latency 2
//   rsp_rdata                 read data (0 for write acks)
//   csb0/web0/wmask0/addr0/din0  macro pins, combinational from the grant
//   dout0                     macro read data
module sram_rw_port_arbiter
  import sram_rw_port_arbiter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstb,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [NUM_WMASKS-1:0] req0_wmask,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [NUM_WMASKS-1:0] req1_wmask,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  csb0,
  output logic                  web0,
  output logic [NUM_WMASKS-1:0] wmask0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  sram_req_t w_req0;
  sram_req_t w_req1;
  sram_req_t w_sel;
  logic      w_grant0;
  logic      w_grant1;
  logic      w_issue;
  logic      w_issue_id;
  logic      r_prio;

  assign w_req0 = '{we: req0_we, wmask: req0_wmask, addr: req0_addr, wdata: req0_wdata};
  assign w_req1 = '{we: req1_we, wmask: req1_wmask, addr: req1_addr, wdata: req1_wdata};

  // Grant: a lone requester always wins, a tie goes to the priority holder.
  // rstb gates the grant so nothing reaches the macro while reset is held.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (rstb) begin
      w_grant0 = req0_valid && (!req1_valid || (r_prio == REQ_LSU));
      w_grant1 = req1_valid && (!req0_valid || (r_prio == REQ_LDR));
    end
  end

  assign w_issue    = w_grant0 | w_grant1;
  assign w_issue_id = w_grant1 ? REQ_LDR : REQ_LSU;
  assign w_sel      = w_grant1 ? w_req1 : w_req0;
  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Priority flips to the other requester after every grant
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_prio <= REQ_LSU;
    end else if (w_grant0) begin
      r_prio <= REQ_LDR;
    end else if (w_grant1) begin
      r_prio <= REQ_LSU;
    end
  end

  // Macro pin drive; idle pins are parked at deselect with zeroed buses
  always_comb begin
    csb0   = 1'b1;
    web0   = 1'b1;
    wmask0 = '0;
    addr0  = '0;
    din0   = '0;
    if (w_issue) begin
      csb0   = 1'b0;
      web0   = ~w_sel.we;
      wmask0 = macro_wmask(w_sel);
      addr0  = w_sel.addr;
      din0   = w_sel.wdata;
    end
  end

  sram_rsp_pipe u_rsp_pipe (
    .clk           (clk),
    .rstb          (rstb),
    .i_issue_valid (w_issue),
    .i_issue_id    (w_issue_id),
    .i_issue_we    (w_sel.we),
    .i_dout        (dout0),
    .o_rsp0_valid  (rsp0_valid),
    .o_rsp1_valid  (rsp1_valid),
    .o_rsp_rdata   (rsp_rdata)
  );

endmodule
